// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit for the 8-bit accumulator CPU: owns pc/ir, fetches over a
// req/ack handshake and steps each instruction through FETCH -> DECODE -> EXECUTE.
module cpu_sequencer #(
    parameter int unsigned       ADDR_W   = 8,
    parameter int unsigned       DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              acc_zero,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [2:0]        alu_operation,
    output logic [DATA_W-1:0] alu_op2,
    output logic              acc_we,
    output logic              halted,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StDecode  = 3'd2,
        StExecute = 3'd3,
        StHalt    = 3'd4
    } state_e;

    localparam logic [2:0] OpLdi = 3'b100;
    localparam logic [2:0] OpJmp = 3'b101;
    localparam logic [2:0] OpJz  = 3'b110;
    localparam logic [2:0] OpHlt = 3'b111;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              run_q;

    logic [2:0]        opcode;
    logic [ADDR_W-1:0] jump_target;

    assign opcode      = ir_q[DATA_W-1 -: 3];
    assign jump_target = {{(ADDR_W-5){1'b0}}, ir_q[4:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            run_q   <= run;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = StDecode;
                end
            end
            StDecode: state_d = StExecute;
            StExecute: begin
                state_d = StFetch;
                case (opcode)
                    OpJmp:   pc_d = jump_target;
                    OpJz:    if (acc_zero) pc_d = jump_target;
                    OpHlt:   state_d = StHalt;
                    default: ;
                endcase
            end
            StHalt: begin
                // Edge-triggered resume so a run level held across HLT does not restart.
                if (run && !run_q) state_d = StFetch;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_req = (state_q == StFetch);
        halted  = (state_q == StHalt);
        acc_we  = (state_q == StExecute) && (opcode <= OpLdi);
    end

    assign mem_addr      = pc_q;
    assign pc            = pc_q;
    assign ir            = ir_q;
    assign alu_operation = opcode;
    assign alu_op2       = {{(DATA_W-5){1'b0}}, ir_q[4:0]};
    assign state         = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: reset, fetch handshake, jumps, pc wrap, halt/resume.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_ack;
    logic       acc_zero;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [2:0] alu_operation;
    logic [7:0] alu_op2;
    logic       acc_we;
    logic       halted;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    cpu_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .acc_zero      (acc_zero),
        .pc            (pc),
        .ir            (ir),
        .alu_operation (alu_operation),
        .alu_op2       (alu_op2),
        .acc_we        (acc_we),
        .halted        (halted),
        .state         (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        reset = 1'b0; run = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00; acc_zero = 1'b0;
        #12;
        chk("rst_state", state, 0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_ir", ir, 8'h00);
        chk("rst_req", mem_req, 0);
        chk("rst_we", acc_we, 0);
        chk("rst_halted", halted, 0);
        chk("rst_op2", alu_op2, 8'h00);

        // 1: zero-wait fetch of ADD 05
        @(negedge clk); reset = 1'b1; run = 1'b1;
        tick();
        chk("t1_fetch", state, 1);
        chk("t1_req", mem_req, 1);
        chk("t1_addr", mem_addr, 8'h00);
        run = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h05;
        tick();
        chk("t1_decode", state, 2);
        chk("t1_ir", ir, 8'h05);
        chk("t1_pc", pc, 8'h01);
        chk("t1_req_drop", mem_req, 0);
        chk("t1_we_dec", acc_we, 0);
        mem_ack = 1'b0;
        tick();
        chk("t1_exec", state, 3);
        chk("t1_we", acc_we, 1);
        chk("t1_aluop", alu_operation, 0);
        chk("t1_op2", alu_op2, 8'h05);
        chk("t1_pc_ex", pc, 8'h01);
        tick();
        chk("t1_refetch", state, 1);
        chk("t1_addr2", mem_addr, 8'h01);
        chk("t1_we_off", acc_we, 0);

        // 2: four wait states, then LDI 1A
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_wait_state", state, 1);
            chk("t2_wait_req", mem_req, 1);
            chk("t2_wait_addr", mem_addr, 8'h01);
            chk("t2_wait_pc", pc, 8'h01);
        end
        mem_ack = 1'b1; mem_rdata = 8'h9A;
        tick();
        chk("t2_decode", state, 2);
        chk("t2_pc", pc, 8'h02);
        chk("t2_ir", ir, 8'h9A);
        mem_ack = 1'b0;
        tick();
        chk("t2_we", acc_we, 1);
        chk("t2_aluop", alu_operation, 3'd4);
        chk("t2_op2", alu_op2, 8'h1A);
        tick();
        chk("t2_addr", mem_addr, 8'h02);

        // 3: JMP 1F, then JZ 03 not taken / taken
        mem_ack = 1'b1; mem_rdata = 8'hBF;
        tick();
        chk("t3_jmp_pc", pc, 8'h03);
        mem_ack = 1'b0;
        tick();
        chk("t3_jmp_we", acc_we, 0);
        tick();
        chk("t3_jmp_addr", mem_addr, 8'h1F);
        mem_ack = 1'b1; mem_rdata = 8'hC3;
        tick();
        chk("t3_jz_pc", pc, 8'h20);
        mem_ack = 1'b0;
        tick();
        chk("t3_jz_we", acc_we, 0);
        tick();
        chk("t3_jz_nt_addr", mem_addr, 8'h20);
        mem_ack = 1'b1; mem_rdata = 8'hC3;
        tick();
        mem_ack = 1'b0; acc_zero = 1'b1;
        tick();
        tick();
        chk("t3_jz_t_addr", mem_addr, 8'h03);
        chk("t3_jz_t_state", state, 1);
        acc_zero = 1'b0;

        // 4: run ADD 00 with ack held high (ignored outside FETCH) until pc reaches FF
        mem_ack = 1'b1; mem_rdata = 8'h00;
        n = 0;
        while (!(state == 3'd1 && mem_addr == 8'hFF) && n < 1000) begin
            tick();
            n++;
        end
        chk("t4_reach_ff", (n < 1000), 1);
        tick();
        chk("t4_wrap_pc", pc, 8'h00);
        mem_ack = 1'b0;
        tick();
        chk("t4_we", acc_we, 1);
        tick();
        chk("t4_addr", mem_addr, 8'h00);

        // 5: HLT with run held high, then resume on a run rising edge
        mem_ack = 1'b1; mem_rdata = 8'hE0; run = 1'b1;
        tick();
        chk("t5_pc", pc, 8'h01);
        mem_ack = 1'b0;
        tick();
        chk("t5_we", acc_we, 0);
        tick();
        chk("t5_halted", halted, 1);
        chk("t5_req", mem_req, 0);
        chk("t5_state", state, 4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold", state, 4);
        end
        run = 1'b0;
        tick();
        chk("t5_still", halted, 1);
        run = 1'b1;
        tick();
        chk("t5_resume", state, 1);
        chk("t5_resume_addr", mem_addr, 8'h01);
        chk("t5_unhalted", halted, 0);
        run = 1'b0;

        // 6: async reset during a waiting fetch; late ack afterwards is ignored
        tick();
        chk("t6_waiting", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("t6_req", mem_req, 0);
        chk("t6_state", state, 0);
        chk("t6_pc", pc, 8'h00);
        mem_ack = 1'b1; mem_rdata = 8'hBF;
        @(negedge clk); reset = 1'b1;
        tick();
        chk("t6_idle", state, 0);
        chk("t6_ir", ir, 8'h00);
        chk("t6_pc_hold", pc, 8'h00);
        mem_ack = 1'b0; run = 1'b1;
        tick();
        chk("t6_fetch", state, 1);
        chk("t6_addr", mem_addr, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
